// File: rtl/dm_mem_arbiter_if.sv
// Bundle of request, response and memory-bus signals for dm_mem_arbiter.
// The master modport is the arbiter's view. The slave modport is the view of
// the surrounding pipeline plus the memory.
interface dm_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              dm_read;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_done;
  logic [DATA_W-1:0] dm_rdata;
  logic              stall;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_done, if_rdata, dm_done, dm_rdata, stall, err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_done, if_rdata, dm_done, dm_rdata, stall, err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_mem_arbiter.sv
// dm_mem_arbiter: shares one single-port memory between instruction fetch and
// the data-memory stage. When both sides contend, they take turns. The arbiter
// freezes the pipeline while an access is outstanding and aborts accesses the
// memory never acknowledges.
module dm_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              reset,
  dm_mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_DM} state_t;
  typedef enum logic {SIDE_IF = 1'b0, SIDE_DM = 1'b1} side_t;

  // Last no-ack cycle of a grant before the access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  side_t             last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic dm_req;
  logic if_pend;
  logic dm_pend;
  logic pick_dm;
  logic dm_is_write;

  // A request whose done is pulsing is being consumed this cycle. It must not
  // be granted again. This keeps at least one IDLE cycle between accesses.
  assign dm_req      = bus.dm_read | bus.dm_write;
  assign dm_is_write = bus.dm_write;
  assign if_pend     = bus.if_req & ~if_done_q;
  assign dm_pend     = dm_req & ~dm_done_q;
  assign pick_dm     = dm_pend & (~if_pend | (last_q == SIDE_IF));

  assign bus.stall     = if_pend | dm_pend;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.err       = err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

  // Arbitration, handshake sequencing and timeout: next-state computation.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_pend | dm_pend) begin
          state_d     = pick_dm ? GRANT_DM : GRANT_IF;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_dm & dm_is_write;
          mem_addr_d  = pick_dm ? bus.dm_addr : bus.if_addr;
          mem_wdata_d = (pick_dm & dm_is_write) ? bus.dm_wdata : '0;
        end
      end
      GRANT_IF, GRANT_DM: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == GRANT_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.mem_rdata;
            last_d     = SIDE_IF;
          end else begin
            dm_done_d = 1'b1;
            // A store returns nothing, so the last load's data is kept.
            if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
            last_d = SIDE_DM;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
          if (state_q == GRANT_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = '0;
            last_d     = SIDE_IF;
          end else begin
            dm_done_d  = 1'b1;
            dm_rdata_d = '0;
            last_d     = SIDE_DM;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs. Reset abandons any access at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= SIDE_IF;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end
endmodule

// File: tb/tb_dm_mem_arbiter.sv
// Testbench for dm_mem_arbiter. It contains an access-level reference model,
// a per-cycle output compare, and directed scenarios with literal checks.
module tb_dm_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dm_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  dm_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Memory responder state.
  int            ack_delay = 0;
  int            req_age = 0;
  bit            stray_ack = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic          prev_req = 1'b0;
  logic [AW-1:0] grant_log[$];
  logic [AW-1:0] cap_addr = '0;
  logic [DW-1:0] cap_wdata = '0;
  logic          cap_we = 1'b0;
  int            req_cycles = 0;
  int            stall_low = 0;
  logic          final_stall = 1'b0;
  logic          if_err_seen = 1'b0;
  logic          dm_err_seen = 1'b0;

  // Reference model: the owner of the access in flight, how long it has held
  // the memory, who was served last, and what every output must show.
  int            m_owner = 0;  // 0 none, 1 IF, 2 DM
  int            m_age = 0;
  int            m_last = 1;
  logic          e_req = 1'b0, e_we = 1'b0, e_ifd = 1'b0, e_dmd = 1'b0, e_err = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_ifr = '0, e_dmr = '0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = 0; m_age = 0; m_last = 1;
    e_req = 0; e_we = 0; e_ifd = 0; e_dmd = 0; e_err = 0;
    e_addr = '0; e_wdata = '0; e_ifr = '0; e_dmr = '0;
  endfunction

  // Close the access in flight. An abort returns zero data and flags err.
  function automatic void model_finish(input bit aborted, input logic [DW-1:0] rd);
    logic was_store;
    was_store = e_we;
    e_req = 0; e_we = 0; e_err = aborted;
    if (m_owner == 1) begin
      e_ifd = 1; e_ifr = aborted ? '0 : rd;
    end else begin
      e_dmd = 1;
      if (aborted) e_dmr = '0;
      else if (!was_store) e_dmr = rd;
    end
    m_last = m_owner;
    m_owner = 0;
  endfunction

  // Work out what the next clock edge must produce from the current inputs.
  function automatic void model_advance();
    bit want_if, want_dm;
    want_if = bus.if_req && !e_ifd;
    want_dm = (bus.dm_read || bus.dm_write) && !e_dmd;
    e_ifd = 0; e_dmd = 0; e_err = 0;
    if (m_owner == 0) begin
      if (want_if || want_dm) begin
        m_owner = (want_dm && !(want_if && m_last == 2)) ? 2 : 1;
        m_age   = 0;
        e_req   = 1;
        e_we    = (m_owner == 2) && bus.dm_write;
        e_addr  = (m_owner == 2) ? bus.dm_addr : bus.if_addr;
        e_wdata = e_we ? bus.dm_wdata : '0;
      end
    end else begin
      m_age++;
      if (bus.mem_ack) model_finish(1'b0, bus.mem_rdata);
      else if (m_age == TO) model_finish(1'b1, '0);
    end
  endfunction

  // Per-cycle compare on the falling edge, then step the model.
  always @(negedge clk) begin
    logic exp_stall;
    if (reset) model_reset();
    exp_stall = ((bus.dm_read | bus.dm_write) & ~e_dmd) | (bus.if_req & ~e_ifd);
    chk_b("mem_req", bus.mem_req, e_req);
    chk_b("mem_we", bus.mem_we, e_we);
    chk_w("mem_addr", bus.mem_addr, e_addr);
    chk_w("mem_wdata", bus.mem_wdata, e_wdata);
    chk_b("if_done", bus.if_done, e_ifd);
    chk_b("dm_done", bus.dm_done, e_dmd);
    chk_b("err", bus.err, e_err);
    chk_w("if_rdata", bus.if_rdata, e_ifr);
    chk_w("dm_rdata", bus.dm_rdata, e_dmr);
    chk_b("stall", bus.stall, exp_stall);
    if (!reset) model_advance();
  end

  // One clock: respond as memory, and log the address of each new grant.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.mem_req) begin
      bus.mem_ack = (ack_delay >= 0) && (req_age == ack_delay);
      req_age++;
      req_cycles++;
    end else begin
      bus.mem_ack = stray_ack;
      req_age = 0;
    end
    bus.mem_rdata = mem_data;
    if (bus.mem_req && !prev_req) begin
      grant_log.push_back(bus.mem_addr);
      cap_addr  = bus.mem_addr;
      cap_wdata = bus.mem_wdata;
      cap_we    = bus.mem_we;
    end
    prev_req = bus.mem_req;
  endtask

  // Hold the raised requests until done. Drop each one in the cycle after its
  // done. Returns the request-to-done latency in cycles.
  task automatic run(input string tag, input bit want_if, input bit want_dm,
                     input int budget, output int cycles);
    bit got_if, got_dm, drop_if, drop_dm;
    int n;
    got_if = !want_if; got_dm = !want_dm; drop_if = 0; drop_dm = 0; n = 0;
    stall_low = 0; req_cycles = 0; if_err_seen = 0; dm_err_seen = 0; final_stall = 1;
    while (!(got_if && got_dm) && n < budget) begin
      step();
      n++;
      if (drop_if) begin bus.if_req = 0; drop_if = 0; end
      if (drop_dm) begin bus.dm_read = 0; bus.dm_write = 0; drop_dm = 0; end
      if (bus.if_done) begin got_if = 1; drop_if = 1; if_err_seen = bus.err; end
      if (bus.dm_done) begin got_dm = 1; drop_dm = 1; dm_err_seen = bus.err; end
      if (got_if && got_dm) final_stall = bus.stall;
      else if (!bus.stall) stall_low++;
    end
    cycles = n + 1;
    chk_b({tag, "_done_seen"}, got_if && got_dm, 1'b1);
    step();
    if (drop_if) bus.if_req = 0;
    if (drop_dm) begin bus.dm_read = 0; bus.dm_write = 0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    int n;
    bus.if_req = 0; bus.if_addr = '0; bus.dm_read = 0; bus.dm_write = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
    repeat (3) step();
    chk_b("rst_mem_req", bus.mem_req, 1'b0);
    chk_b("rst_if_done", bus.if_done, 1'b0);
    chk_w("rst_dm_rdata", bus.dm_rdata, 32'h0);
    reset = 0;
    step();

    // Instruction fetch, ack one cycle after mem_req appears.
    ack_delay = 1; mem_data = 32'h8C220004;
    bus.if_req = 1; bus.if_addr = 32'h40;
    run("t1", 1, 0, 20, cyc);
    chk_w("t1_addr", cap_addr, 32'h40);
    chk_b("t1_we", cap_we, 1'b0);
    chk_w("t1_if_rdata", bus.if_rdata, 32'h8C220004);
    chk_b("t1_stall_in_done", final_stall, 1'b0);
    chk_w("t1_latency", cyc, 4);
    chk_b("t1_err", if_err_seen, 1'b0);
    chk_w("t1_model_ifr", e_ifr, 32'h8C220004);

    // Store, ack on the first mem_req cycle.
    ack_delay = 0; mem_data = 32'h11112222;
    bus.dm_write = 1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEADBEEF;
    run("t2", 0, 1, 20, cyc);
    chk_b("t2_we", cap_we, 1'b1);
    chk_w("t2_addr", cap_addr, 32'h100);
    chk_w("t2_wdata", cap_wdata, 32'hDEADBEEF);
    chk_w("t2_dm_rdata_kept", bus.dm_rdata, 32'h0);
    chk_w("t2_latency", cyc, 3);
    chk_b("t2_err", dm_err_seen, 1'b0);

    // Load, then a store with both strobes high must not disturb load data.
    mem_data = 32'h12345678;
    bus.dm_read = 1; bus.dm_addr = 32'h108; bus.dm_wdata = 32'h99999999;
    run("t2b", 0, 1, 20, cyc);
    chk_w("t2b_dm_rdata", bus.dm_rdata, 32'h12345678);
    chk_b("t2b_we", cap_we, 1'b0);
    chk_w("t2b_wdata_zero", cap_wdata, 32'h0);
    chk_w("t2b_model_dmr", e_dmr, 32'h12345678);
    mem_data = 32'h00000055;
    bus.dm_read = 1; bus.dm_write = 1; bus.dm_addr = 32'h10C; bus.dm_wdata = 32'hCAFEF00D;
    run("t2c", 0, 1, 20, cyc);
    chk_b("t2c_we", cap_we, 1'b1);
    chk_w("t2c_wdata", cap_wdata, 32'hCAFEF00D);
    chk_w("t2c_dm_rdata_kept", bus.dm_rdata, 32'h12345678);

    // Stray acks while idle must be ignored.
    stray_ack = 1;
    repeat (3) step();
    stray_ack = 0;
    step();
    chk_b("idle_ack_req", bus.mem_req, 1'b0);
    chk_b("idle_ack_dm_done", bus.dm_done, 1'b0);

    // After reset, a simultaneous request goes to DM first, then IF.
    reset = 1; step(); step(); reset = 0;
    ack_delay = 1; mem_data = 32'h0BADF00D;
    base = grant_log.size();
    bus.if_req = 1; bus.if_addr = 32'h80; bus.dm_read = 1; bus.dm_addr = 32'h180;
    run("t3", 1, 1, 30, cyc);
    if (grant_log.size() >= base + 2) begin
      chk_w("t3_first_grant", grant_log[base], 32'h180);
      chk_w("t3_second_grant", grant_log[base+1], 32'h80);
    end else chk_w("t3_grant_count", grant_log.size() - base, 2);
    chk_w("t3_stall_low_cycles", stall_low, 0);
    chk_w("t3_if_rdata", bus.if_rdata, 32'h0BADF00D);
    chk_w("t3_dm_rdata", bus.dm_rdata, 32'h0BADF00D);

    // Continuous contention alternates DM, IF, DM, IF.
    ack_delay = 0; mem_data = 32'hA5A50001;
    base = grant_log.size();
    bus.if_req = 1; bus.if_addr = 32'h200; bus.dm_read = 1; bus.dm_addr = 32'h300;
    n = 0;
    while (grant_log.size() < base + 4 && n < 40) begin step(); n++; end
    bus.dm_read = 0;
    n = 0;
    while (!bus.if_done && n < 10) begin step(); n++; end
    chk_b("t4_if_done_seen", bus.if_done, 1'b1);
    step();
    bus.if_req = 0;
    if (grant_log.size() >= base + 4) begin
      for (int i = 0; i < 4; i++)
        chk_w("t4_grant_order", grant_log[base+i], (i % 2 == 0) ? 32'h300 : 32'h200);
    end else chk_w("t4_grant_count", grant_log.size() - base, 4);
    step();

    // No ack: abort after exactly TO cycles of mem_req.
    ack_delay = -1; mem_data = 32'h77777777;
    bus.dm_read = 1; bus.dm_addr = 32'h500;
    run("t5", 0, 1, 30, cyc);
    chk_w("t5_req_cycles", req_cycles, TO);
    chk_b("t5_err_with_done", dm_err_seen, 1'b1);
    chk_w("t5_dm_rdata_zero", bus.dm_rdata, 32'h0);
    chk_w("t5_latency", cyc, TO + 2);
    chk_b("t5_idle_after", bus.mem_req, 1'b0);

    // Reset in the middle of a fetch, then a normal fetch.
    bus.if_req = 1; bus.if_addr = 32'h60;
    n = 0;
    do begin step(); n++; end while (!bus.mem_req && n < 5);
    chk_b("t6_req_up", bus.mem_req, 1'b1);
    #1 reset = 1;
    #1;
    chk_b("t6_req_dropped", bus.mem_req, 1'b0);
    chk_b("t6_no_done", bus.if_done, 1'b0);
    chk_b("t6_no_err", bus.err, 1'b0);
    chk_w("t6_if_rdata_cleared", bus.if_rdata, 32'h0);
    bus.if_req = 0;
    step(); step();
    reset = 0;
    step();
    ack_delay = 1; mem_data = 32'h20000044;
    bus.if_req = 1; bus.if_addr = 32'h44;
    run("t6", 1, 0, 20, cyc);
    chk_w("t6_addr", cap_addr, 32'h44);
    chk_w("t6_if_rdata", bus.if_rdata, 32'h20000044);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dm_mem_arbiter.md
Name: dm_mem_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF) and the data-memory stage (DM).
- The DM side is driven by the EX/DM pipeline register outputs: mem read/write strobes, address and write data.
- Sequences each access with a req/ack handshake, returns read data to the winning requester, and drives a global pipeline stall so that PC, IF/ID, ID/EX and EX/DM hold while an access is outstanding.
- A timeout counter aborts hung accesses.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, memory data width.
- TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before abort; legal range 2..255.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  IF fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch address (PC).
- dm_read  in  1  load request from EX/DM stage; held until dm_done.
- dm_write  in  1  store request from EX/DM stage; held until dm_done.
- dm_addr  in  ADDR_W  load/store address (ALU result).
- dm_wdata  in  DATA_W  store data.
- if_done  out  1  one-cycle pulse: fetch complete.
- if_rdata  out  DATA_W  fetched instruction; valid with if_done, held until next if_done.
- dm_done  out  1  one-cycle pulse: load/store complete.
- dm_rdata  out  DATA_W  load data; valid with dm_done, held until next load completes.
- stall  out  1  combinational pipeline freeze.
- err  out  1  one-cycle pulse with the done pulse of an aborted (timed-out) access.
- mem_req  out  1  memory request; held until mem_ack or abort.
- mem_we  out  1  write enable, registered with mem_req.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory.

Behaviour:
- Reset (async, immediate):
  - State IDLE, last_grant=IF, timeout counter=0.
  - All outputs 0, except stall, which follows its combinational equation.
- dm_req = dm_read | dm_write. If both strobes are high, the access is a write.
- States:
  - IDLE:
    - only dm_req → GRANT_DM.
    - only if_req → GRANT_IF.
    - both → grant the side opposite to last_grant.
    - neither → stay.
  - On the IDLE→GRANT_x edge: latch mem_addr, mem_wdata (DM write only, else 0) and mem_we (1 only for DM write); set mem_req=1; counter=0. mem_req is first visible the cycle after arbitration.
  - GRANT_x, mem_ack=1:
    - mem_req←0, mem_we←0.
    - Pulse x_done next cycle.
    - For IF or a DM load: x_rdata←mem_rdata. A store leaves dm_rdata unchanged.
    - last_grant←x; state→IDLE.
  - GRANT_x, no ack:
    - counter++.
    - When counter==TIMEOUT-1 with no ack: mem_req←0, x_done and err pulse next cycle, x_rdata←0, last_grant←x, →IDLE.
- IDLE is entered for at least one cycle between accesses; there is no back-to-back issue.
- mem_ack while IDLE is ignored.
- A requester dropping its request mid-access is illegal; the access still completes and its done still pulses.
- stall = (dm_req & ~dm_done) | (if_req & ~if_done). It deasserts in the done cycle, so the pipeline advances on the same edge the data is consumed.
- Minimum latency with ack on the first mem_req cycle: request → done = 3 cycles (arbitrate, mem_req, done).
- Reset mid-access: mem_req drops immediately; no done pulse; the memory must tolerate an abandoned request.

Test Plan:
1. Reset, then if_req=1, if_addr=0x40, mem_ack one cycle after mem_req with mem_rdata=0x8C220004 → mem_addr=0x40, mem_we=0, if_done pulse, if_rdata=0x8C220004, stall low in the done cycle.
2. dm_write=1, dm_addr=0x100, dm_wdata=0xDEADBEEF → mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, dm_done pulse, dm_rdata unchanged (0).
3. if_req and dm_read both raised in the same cycle after reset → DM granted first (last_grant=IF); IF is granted in the following IDLE; both done pulses occur and stall stays high throughout.
4. Continuous if_req plus repeated dm_read → grants alternate DM, IF, DM, IF; neither side starves.
5. TIMEOUT=4, dm_read held, no mem_ack → mem_req high exactly 4 cycles, then dm_done and err pulse together, dm_rdata=0, state IDLE.
6. Assert reset while mem_req=1 in GRANT_IF → mem_req, if_done, err all 0 immediately; after release, an if_req at 0x44 is granted normally.
